// File: rtl/pipelined_shifter_if.sv
// Request/response bundle for the pipelined shift unit.
// The master side issues operations and consumes results; the slave side is the shifter.
interface pipelined_shifter_if #(
    parameter int unsigned XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] A;
    logic [XLEN-1:0] B;
    logic [1:0]      op;
    logic            word;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] S;

    modport master (
        output in_valid, A, B, op, word, out_ready,
        input  in_ready, out_valid, S
    );

    modport slave (
        input  in_valid, A, B, op, word, out_ready,
        output in_ready, out_valid, S
    );
endinterface

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter: SLL/SRL/SRA plus the RV64 word forms.
// log2(XLEN) mux levels (level k shifts by 2^k) are spread over STAGES registers,
// ceil(log2(XLEN)/STAGES) levels per stage, lowest levels first. The whole pipe
// freezes while the output is stalled, so bubbles are never compressed.
module pipelined_shifter #(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned STAGES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    pipelined_shifter_if.slave bus
);
    localparam int ShW         = $clog2(XLEN);
    localparam int NumStages   = int'(STAGES);
    localparam int LvlPerStage = (ShW + NumStages - 1) / NumStages;

    if (XLEN != 32 && XLEN != 64) begin : gen_bad_xlen
        $error("pipelined_shifter: XLEN must be 32 or 64");
    end
    if (NumStages < 1 || NumStages > ShW) begin : gen_bad_stages
        $error("pipelined_shifter: STAGES must be in 1..log2(XLEN)");
    end

    // op and word travel with the data so each stage can steer its own levels.
    typedef struct packed {
        logic [XLEN-1:0] data;
        logic [ShW-1:0]  sh;
        logic [1:0]      op;
        logic            word;
    } stage_t;

    stage_t            stage_q  [NumStages];
    stage_t            stage_d  [NumStages];
    stage_t            stage_in [NumStages];
    logic [NumStages-1:0] valid_q;
    logic [NumStages-1:0] valid_d;
    logic [NumStages-1:0] valid_in;
    stage_t            entry;
    logic              stall;
    logic              accept;

    // Upper shift-amount bits are architecturally ignored.
    logic unused_b;
    assign unused_b = ^bus.B[XLEN-1:ShW];

    assign stall         = valid_q[NumStages-1] & ~bus.out_ready;
    assign accept        = bus.in_valid & ~stall;
    assign bus.in_ready  = ~stall;
    assign bus.out_valid = valid_q[NumStages-1];
    assign bus.S         = stage_q[NumStages-1].data;

    // Format an incoming request. In word mode the source is pre-extended from A[31:0]
    // (sign for SRAW, zero otherwise) so full-width right shifts fill the low word correctly.
    always_comb begin
        logic word_eff;
        word_eff   = (XLEN == 64) ? bus.word : 1'b0;
        entry      = '0;
        entry.op   = bus.op;
        entry.word = word_eff;
        entry.sh   = bus.B[ShW-1:0];
        entry.data = bus.A;
        if (word_eff) begin
            entry.sh[ShW-1] = 1'b0;
            entry.data      = (bus.op == 2'b10) ? XLEN'($signed(bus.A[31:0]))
                                                : XLEN'(bus.A[31:0]);
        end
    end

    // Stage inputs: stage 0 takes the accepted request, later stages take their predecessor.
    always_comb begin
        stage_in[0] = entry;
        valid_in[0] = accept;
        for (int s = 1; s < NumStages; s++) begin
            stage_in[s] = stage_q[s-1];
            valid_in[s] = valid_q[s-1];
        end
    end

    // Per-stage mux levels and next state; data only loads for a live op so S holds otherwise.
    always_comb begin
        stage_t cur;
        stage_d = stage_q;
        valid_d = valid_q;
        for (int s = 0; s < NumStages; s++) begin
            cur = stage_in[s];
            for (int k = 0; k < ShW; k++) begin
                if ((k / LvlPerStage) == s && cur.sh[k]) begin
                    case (cur.op)
                        2'b01:   cur.data = cur.data >> (1 << k);
                        2'b10:   cur.data = $unsigned($signed(cur.data) >>> (1 << k));
                        default: cur.data = cur.data << (1 << k);
                    endcase
                end
            end
            if (s == NumStages - 1 && cur.word) begin
                cur.data = XLEN'($signed(cur.data[31:0]));
            end

            if (flush) begin
                valid_d[s] = 1'b0;
            end else if (!stall) begin
                valid_d[s] = valid_in[s];
                if (valid_in[s]) begin
                    stage_d[s] = cur;
                end
            end
        end
    end

    // Pipeline registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            for (int s = 0; s < NumStages; s++) begin
                stage_q[s] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            stage_q <= stage_d;
        end
    end
endmodule

// File: tb/tb_pipelined_shifter.sv
// Bench for pipelined_shifter: three instances (STAGES = 2, 1, 6) share one stimulus stream.
// Each instance has a cycle-accurate scoreboard built from a plain-arithmetic shift model.
module tb_pipelined_shifter;
    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [63:0] A;
    logic [63:0] B;
    logic [1:0]  op;
    logic        word;
    logic        out_ready;

    logic [2:0]  ov;
    logic [2:0]  rdy;
    logic [63:0] s_out [3];
    int          qlen  [3];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] exp;
        int          age;
    } ent_t;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [1:0]  op;
        logic        word;
        logic [63:0] exp;
    } vec_t;

    function automatic logic [63:0] ref_shift(logic [63:0] a, logic [63:0] b,
                                              logic [1:0] o, logic w);
        logic [31:0] r32;
        logic [63:0] r;
        int          sh;
        if (w) begin
            sh = int'(b[4:0]);
            case (o)
                2'b01:   r32 = a[31:0] >> sh;
                2'b10:   r32 = $unsigned($signed(a[31:0]) >>> sh);
                default: r32 = a[31:0] << sh;
            endcase
            r = {{32{r32[31]}}, r32};
        end else begin
            sh = int'(b[5:0]);
            case (o)
                2'b01:   r = a >> sh;
                2'b10:   r = $unsigned($signed(a) >>> sh);
                default: r = a << sh;
            endcase
        end
        return r;
    endfunction

    task automatic check(input string name, input int stages, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s (STAGES=%0d): got %h, expected %h", name, stages, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        localparam int Stg = (g == 0) ? 2 : ((g == 1) ? 1 : 6);

        pipelined_shifter_if #(.XLEN(64)) ifc ();

        assign ifc.in_valid  = in_valid;
        assign ifc.A         = A;
        assign ifc.B         = B;
        assign ifc.op        = op;
        assign ifc.word      = word;
        assign ifc.out_ready = out_ready;
        assign ov[g]         = ifc.out_valid;
        assign rdy[g]        = ifc.in_ready;
        assign s_out[g]      = ifc.S;

        pipelined_shifter #(.XLEN(64), .STAGES(Stg)) u_dut (
            .clk  (clk),
            .reset(reset),
            .flush(flush),
            .bus  (ifc.slave)
        );

        // Scoreboard: each accepted op ages one step per unstalled edge and is visible at age Stg.
        ent_t        q[$];
        logic [63:0] s_model;
        bit          armed;

        always @(negedge clk) begin
            bit mv;
            mv = (q.size() > 0) && (q[0].age == Stg);
            if (armed) begin
                check("sb out_valid", Stg, 64'(ov[g]), 64'(mv));
                check("sb in_ready", Stg, 64'(rdy[g]), 64'(!(mv && !out_ready)));
                check("sb S", Stg, s_out[g], s_model);
            end
            if (reset) begin
                q.delete();
                s_model = '0;
                armed   = 1'b1;
            end else if (armed) begin
                if (flush) begin
                    q.delete();
                end else if (!(mv && !out_ready)) begin
                    if (mv) void'(q.pop_front());
                    foreach (q[i]) q[i].age++;
                    if (in_valid) q.push_back('{exp: ref_shift(A, B, op, word), age: 1});
                    if (q.size() > 0 && q[0].age == Stg) s_model = q[0].exp;
                end
            end
            qlen[g] = q.size();
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t        vecs[$];
        int          stg[3];
        logic [63:0] got[$];

        stg = '{2, 1, 6};
        vecs.push_back('{64'h8000_0000_0000_0000, 64'd63, 2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF});
        vecs.push_back('{64'h8000_0000_0000_0000, 64'd63, 2'b01, 1'b0, 64'h0000_0000_0000_0001});
        vecs.push_back('{64'h1, 64'h41, 2'b00, 1'b0, 64'h2});
        vecs.push_back('{64'h1, 64'd31, 2'b00, 1'b1, 64'hFFFF_FFFF_8000_0000});
        vecs.push_back('{64'h8000_0000, 64'd4, 2'b10, 1'b1, 64'hFFFF_FFFF_F800_0000});
        vecs.push_back('{64'hFFFF_FFFF_8000_0000, 64'h24, 2'b01, 1'b1, 64'h0000_0000_0800_0000});
        vecs.push_back('{64'h3, 64'd2, 2'b11, 1'b0, 64'hC});
        vecs.push_back('{64'h7000_0000_0000_0000, 64'd4, 2'b10, 1'b0, 64'h0700_0000_0000_0000});
        vecs.push_back('{64'h1234_5678_8765_4321, 64'h40, 2'b01, 1'b1, 64'hFFFF_FFFF_8765_4321});
        vecs.push_back('{64'hDEAD_BEEF_0123_4567, 64'h1_0000_0000, 2'b01, 1'b0,
                         64'hDEAD_BEEF_0123_4567});
        vecs.push_back('{64'h7FFF_FFFF, 64'h3F, 2'b10, 1'b1, 64'h0});
        vecs.push_back('{64'hFF, 64'd60, 2'b00, 1'b0, 64'hF000_0000_0000_0000});

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        A = '0; B = '0; op = 2'b00; word = 1'b0;
        repeat (3) cyc();
        reset = 1'b0;
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            check("reset out_valid", stg[g], 64'(ov[g]), 64'd0);
            check("reset S", stg[g], s_out[g], 64'd0);
            check("reset in_ready", stg[g], 64'(rdy[g]), 64'd1);
        end
        cyc();

        // Walking-one left shifts, back to back; each result exactly STAGES cycles later.
        for (int c = 0; c < 72; c++) begin
            in_valid = (c < 64); A = 64'h1; B = 64'(c); op = 2'b00; word = 1'b0;
            @(negedge clk);
            for (int g = 0; g < 3; g++) begin
                int i;
                i = c - stg[g];
                check("sll walk out_valid", stg[g], 64'(ov[g]), 64'(i >= 0 && i < 64));
                if (i >= 0 && i < 64) check("sll walk S", stg[g], s_out[g], 64'h1 << i);
            end
            cyc();
        end
        in_valid = 1'b0;
        repeat (4) cyc();

        // Directed vectors, one at a time.
        for (int v = 0; v < vecs.size(); v++) begin
            in_valid = 1'b1; A = vecs[v].a; B = vecs[v].b; op = vecs[v].op; word = vecs[v].word;
            cyc();
            in_valid = 1'b0;
            repeat (7) cyc();
            @(negedge clk);
            for (int g = 0; g < 3; g++) begin
                check($sformatf("vec%0d S", v), stg[g], s_out[g], vecs[v].exp);
            end
            cyc();
        end

        // Output stall: three ops, then out_ready low for five cycles.
        got.delete();
        for (int c = 0; c < 14; c++) begin
            in_valid = (c < 3); A = 64'(5 + c); B = 64'd1; op = 2'b00; word = 1'b0;
            out_ready = !(c >= 3 && c < 8);
            @(negedge clk);
            if (ov[0] && out_ready) got.push_back(s_out[0]);
            if (c >= 3 && c < 8) begin
                check("stall in_ready", 2, 64'(rdy[0]), 64'd0);
                check("stall out_valid", 2, 64'(ov[0]), 64'd1);
                check("stall S", 2, s_out[0], 64'd12);
            end
            cyc();
        end
        out_ready = 1'b1;
        check("stall result count", 2, 64'(got.size()), 64'd3);
        if (got.size() == 3) begin
            check("stall result 0", 2, got[0], 64'd10);
            check("stall result 1", 2, got[1], 64'd12);
            check("stall result 2", 2, got[2], 64'd14);
        end
        repeat (4) cyc();

        // Flush after two accepts, with a request in the flush cycle; then a clean op.
        for (int c = 0; c < 13; c++) begin
            in_valid = (c < 3) || (c == 9); flush = (c == 2);
            A = 64'h1; B = (c == 9) ? 64'd5 : 64'(c + 1); op = 2'b00; word = 1'b0;
            @(negedge clk);
            if (c == 2) check("pre-flush S", 2, s_out[0], 64'd2);
            if (c >= 3 && c <= 10) check("post-flush out_valid", 2, 64'(ov[0]), 64'd0);
            if (c >= 3 && c < 11) check("post-flush S hold", 2, s_out[0], 64'd2);
            if (c == 11) begin
                check("after-flush op out_valid", 2, 64'(ov[0]), 64'd1);
                check("after-flush op S", 2, s_out[0], 64'd32);
            end
            cyc();
        end
        flush = 1'b0; in_valid = 1'b0;
        repeat (8) cyc();

        // Reset mid-pipe.
        for (int c = 0; c < 6; c++) begin
            in_valid = (c < 2); reset = (c == 2); A = 64'h3; B = 64'(c + 7); op = 2'b00;
            @(negedge clk);
            if (c == 3) begin
                for (int g = 0; g < 3; g++) begin
                    check("mid reset out_valid", stg[g], 64'(ov[g]), 64'd0);
                    check("mid reset S", stg[g], s_out[g], 64'd0);
                    check("mid reset in_ready", stg[g], 64'(rdy[g]), 64'd1);
                end
            end
            cyc();
        end
        reset = 1'b0; in_valid = 1'b0;

        // Random traffic with backpressure, occasional flush and reset.
        for (int c = 0; c < 3000; c++) begin
            reset     = ($urandom_range(0, 299) == 0);
            flush     = ($urandom_range(0, 59) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            A         = {$urandom(), $urandom()};
            B         = {$urandom(), $urandom()};
            op        = 2'($urandom());
            word      = 1'($urandom());
            cyc();
        end

        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (12) cyc();
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            check("drain queue empty", stg[g], 64'(qlen[g]), 64'd0);
            check("drain out_valid", stg[g], 64'(ov[g]), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
